// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: register reads into operand latches,
// execute wait, result write-back over the shared bus.
module alu_op_sequencer #(
  parameter int REG_ADDR_W = 3,
  parameter int EXEC_WAIT  = 1
) (
  input  logic                  ALU_clock,
  input  logic                  ALU_reset,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_op,
  output logic                  reg_rd_en,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  output logic                  reg_wr_en,
  output logic [REG_ADDR_W-1:0] reg_wr_addr,
  output logic                  latched_bus1_en,
  output logic                  latched_bus2_en,
  output logic [3:0]            alu_control,
  output logic                  bus_out_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC,
    S_WRITE, S_DONE, S_ERR
  } state_e;

  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] WAIT_LD = 4'(EXEC_WAIT - 1);

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] a_q, a_d;
  logic [REG_ADDR_W-1:0] b_q, b_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  legal;

  assign legal = (opcode[3] == 1'b0) && (opcode != 4'b0000);

  always_ff @(posedge ALU_clock) begin
    if (ALU_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          a_d     = src_a;
          b_d     = src_b;
          dst_d   = dst;
          state_d = legal ? S_LOAD_A : S_ERR;
        end
      end
      S_LOAD_A: begin
        if (op_q == OP_NOT) begin
          state_d = S_EXEC;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        state_d = S_EXEC;
        cnt_d   = WAIT_LD;
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) state_d = S_WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    illegal_op      = 1'b0;
    reg_rd_en       = 1'b0;
    reg_rd_addr     = '0;
    reg_wr_en       = 1'b0;
    reg_wr_addr     = '0;
    latched_bus1_en = 1'b0;
    latched_bus2_en = 1'b0;
    alu_control     = 4'b0000;
    bus_out_en      = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_LOAD_A: begin
        busy            = 1'b1;
        reg_rd_en       = 1'b1;
        reg_rd_addr     = a_q;
        latched_bus1_en = 1'b1;
        alu_control     = op_q;
      end
      S_LOAD_B: begin
        busy            = 1'b1;
        reg_rd_en       = 1'b1;
        reg_rd_addr     = b_q;
        latched_bus2_en = 1'b1;
        alu_control     = op_q;
      end
      S_EXEC: begin
        busy        = 1'b1;
        alu_control = op_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        bus_out_en  = 1'b1;
        reg_wr_en   = 1'b1;
        reg_wr_addr = dst_q;
        alu_control = op_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_ERR: begin
        busy       = 1'b1;
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a register-file,
// operand-latch and ALU environment on a shared 16-bit bus.
module tb_alu_op_sequencer;

  logic       ALU_clock = 1'b0;
  logic       ALU_reset;
  logic       start, start2;
  logic [3:0] opcode, opcode2;
  logic [2:0] src_a, src_b, dst;
  logic [2:0] src_a2, src_b2, dst2;

  logic       busy, done, illegal_op, reg_rd_en, reg_wr_en;
  logic [2:0] reg_rd_addr, reg_wr_addr;
  logic       latched_bus1_en, latched_bus2_en, bus_out_en;
  logic [3:0] alu_control;

  logic       busy2, done2, illegal_op2, reg_rd_en2, reg_wr_en2;
  logic [2:0] reg_rd_addr2, reg_wr_addr2;
  logic       l1_en2, l2_en2, bus_out_en2;
  logic [3:0] alu_control2;

  int nerr = 0;
  int nchk = 0;

  always #5 ALU_clock = ~ALU_clock;

  alu_op_sequencer #(.REG_ADDR_W(3), .EXEC_WAIT(1)) dut (
    .ALU_clock(ALU_clock), .ALU_reset(ALU_reset),
    .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .illegal_op(illegal_op),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .latched_bus1_en(latched_bus1_en),
    .latched_bus2_en(latched_bus2_en),
    .alu_control(alu_control), .bus_out_en(bus_out_en)
  );

  alu_op_sequencer #(.REG_ADDR_W(3), .EXEC_WAIT(4)) dut2 (
    .ALU_clock(ALU_clock), .ALU_reset(ALU_reset),
    .start(start2), .opcode(opcode2),
    .src_a(src_a2), .src_b(src_b2), .dst(dst2),
    .busy(busy2), .done(done2), .illegal_op(illegal_op2),
    .reg_rd_en(reg_rd_en2), .reg_rd_addr(reg_rd_addr2),
    .reg_wr_en(reg_wr_en2), .reg_wr_addr(reg_wr_addr2),
    .latched_bus1_en(l1_en2),
    .latched_bus2_en(l2_en2),
    .alu_control(alu_control2), .bus_out_en(bus_out_en2)
  );

  // Environment: register file, operand latches, ALU.
  logic [15:0] rf [8];
  logic [15:0] lat_a, lat_b, bus;
  logic        poke;
  logic [2:0]  poke_a;
  logic [15:0] poke_d;

  function automatic logic [15:0] alu(input logic [3:0] c,
                                      input logic [15:0] a, b);
    case (c)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return ~a;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return ~(a ^ b);
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    bus = 16'h0000;
    if (reg_rd_en)  bus = rf[reg_rd_addr];
    if (bus_out_en) bus = alu(alu_control, lat_a, lat_b);
  end

  always @(posedge ALU_clock) begin
    if (poke)           rf[poke_a] <= poke_d;
    else if (reg_wr_en) rf[reg_wr_addr] <= bus;
    if (latched_bus1_en) lat_a <= bus;
    if (latched_bus2_en) lat_b <= bus;
  end

  logic [17:0] o1;
  assign o1 = {busy, done, illegal_op, reg_rd_en, reg_rd_addr,
               reg_wr_en, reg_wr_addr, latched_bus1_en,
               latched_bus2_en, alu_control, bus_out_en};

  function automatic logic [17:0] ev(
    input logic bs, dn, il, rd, input logic [2:0] ra,
    input logic wr, input logic [2:0] wa,
    input logic l1, l2, input logic [3:0] ct, input logic bo);
    return {bs, dn, il, rd, ra, wr, wa, l1, l2, ct, bo};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs, exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ALU_clock);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    poke = 1'b1; poke_a = a; poke_d = d;
    tick();
    poke = 1'b0;
  endtask

  task automatic req(input logic [3:0] op,
                     input logic [2:0] a, b, d);
    start = 1'b1; opcode = op; src_a = a; src_b = b; dst = d;
    tick();
    start = 1'b0;
  endtask

  logic mon_on = 1'b0;
  always @(negedge ALU_clock) begin
    if (mon_on) begin
      chk("rd_vs_busout", {31'd0, reg_rd_en & bus_out_en}, 0);
      chk("latch_excl", {31'd0, latched_bus1_en & latched_bus2_en}, 0);
      chk("rd_addr_idle", reg_rd_en ? 32'd0 : 32'(reg_rd_addr), 0);
      chk("wr_addr_idle", reg_wr_en ? 32'd0 : 32'(reg_wr_addr), 0);
      chk("rd_vs_busout2", {31'd0, reg_rd_en2 & bus_out_en2}, 0);
      chk("latch_excl2", {31'd0, l1_en2 & l2_en2}, 0);
    end
  end

  localparam logic [17:0] IDLE_V = 18'd0;

  initial begin
    int cnt;
    ALU_reset = 1'b1; start = 1'b0; start2 = 1'b0; poke = 1'b0;
    poke_a = '0; poke_d = '0;
    opcode = '0; src_a = '0; src_b = '0; dst = '0;
    opcode2 = '0; src_a2 = '0; src_b2 = '0; dst2 = '0;
    tick(); tick();
    ALU_reset = 1'b0;
    chk("reset_outs", 32'(o1), 32'(IDLE_V));
    chk("reset_outs2", {31'd0, busy2 | done2 | reg_rd_en2}, 0);
    mon_on = 1'b1;

    // ADD R3 = R1 + R2
    wr_reg(3'd1, 16'h0005);
    wr_reg(3'd2, 16'h0003);
    wr_reg(3'd3, 16'h0000);
    req(4'd1, 3'd1, 3'd2, 3'd3);
    chk("add_loadA", 32'(o1), 32'(ev(1,0,0,1,1,0,0,1,0,1,0)));
    tick();
    chk("add_loadB", 32'(o1), 32'(ev(1,0,0,1,2,0,0,0,1,1,0)));
    tick();
    chk("add_exec", 32'(o1), 32'(ev(1,0,0,0,0,0,0,0,0,1,0)));
    tick();
    chk("add_write", 32'(o1), 32'(ev(1,0,0,0,0,1,3,0,0,1,1)));
    tick();
    chk("add_done", 32'(o1), 32'(ev(1,1,0,0,0,0,0,0,0,0,0)));
    tick();
    chk("add_idle", 32'(o1), 32'(IDLE_V));
    chk("add_R3", 32'(rf[3]), 32'h0008);

    // NOT R4 = ~R4, no LOAD_B cycle
    wr_reg(3'd4, 16'h00FF);
    req(4'd3, 3'd4, 3'd7, 3'd4);
    chk("not_loadA", 32'(o1), 32'(ev(1,0,0,1,4,0,0,1,0,3,0)));
    tick();
    chk("not_exec", 32'(o1), 32'(ev(1,0,0,0,0,0,0,0,0,3,0)));
    tick();
    chk("not_write", 32'(o1), 32'(ev(1,0,0,0,0,1,4,0,0,3,1)));
    tick();
    chk("not_done", 32'(o1), 32'(ev(1,1,0,0,0,0,0,0,0,0,0)));
    tick();
    chk("not_idle", 32'(o1), 32'(IDLE_V));
    chk("not_R4", 32'(rf[4]), 32'hFF00);

    // Illegal opcodes
    req(4'b0000, 3'd1, 3'd2, 3'd3);
    chk("ill0_err", 32'(o1), 32'(ev(1,0,1,0,0,0,0,0,0,0,0)));
    tick();
    chk("ill0_idle", 32'(o1), 32'(IDLE_V));
    req(4'b1010, 3'd1, 3'd2, 3'd4);
    chk("ill10_err", 32'(o1), 32'(ev(1,0,1,0,0,0,0,0,0,0,0)));
    tick();
    chk("ill10_idle", 32'(o1), 32'(IDLE_V));
    chk("ill_R3", 32'(rf[3]), 32'h0008);
    chk("ill_R4", 32'(rf[4]), 32'hFF00);

    // SUB with a stray start during EXEC
    wr_reg(3'd1, 16'h0003);
    wr_reg(3'd2, 16'h0005);
    req(4'd2, 3'd1, 3'd2, 3'd3);
    tick();
    tick();
    chk("sub_exec", 32'(o1), 32'(ev(1,0,0,0,0,0,0,0,0,2,0)));
    start = 1'b1; opcode = 4'd1; src_a = 3'd5; dst = 3'd5;
    tick();
    start = 1'b0;
    chk("sub_write", 32'(o1), 32'(ev(1,0,0,0,0,1,3,0,0,2,1)));
    tick();
    chk("sub_done", 32'(o1), 32'(ev(1,1,0,0,0,0,0,0,0,0,0)));
    tick();
    chk("sub_idle", 32'(o1), 32'(IDLE_V));
    tick();
    chk("sub_no_second", 32'(o1), 32'(IDLE_V));
    chk("sub_R3", 32'(rf[3]), 32'hFFFE);

    // Reset during EXEC aborts the write
    wr_reg(3'd6, 16'hAAAA);
    req(4'd1, 3'd1, 3'd2, 3'd6);
    tick();
    tick();
    chk("rst_exec", 32'(o1), 32'(ev(1,0,0,0,0,0,0,0,0,1,0)));
    ALU_reset = 1'b1;
    tick();
    ALU_reset = 1'b0;
    chk("rst_outs0", 32'(o1), 32'(IDLE_V));
    tick();
    chk("rst_outs1", 32'(o1), 32'(IDLE_V));
    chk("rst_R6", 32'(rf[6]), 32'h0000AAAA);
    req(4'd1, 3'd1, 3'd2, 3'd6);
    tick(); tick(); tick();
    chk("rst2_write", 32'(o1), 32'(ev(1,0,0,0,0,1,6,0,0,1,1)));
    tick();
    chk("rst2_done", 32'(o1), 32'(ev(1,1,0,0,0,0,0,0,0,0,0)));
    tick();
    chk("rst2_R6", 32'(rf[6]), 32'h0008);

    // EXEC_WAIT=4, back-to-back operations
    for (int k = 0; k < 2; k++) begin
      start2 = 1'b1; opcode2 = 4'd4;
      src_a2 = 3'd1; src_b2 = 3'd2; dst2 = 3'd3;
      tick();
      start2 = 1'b0;
      cnt = 1;
      while (!done2 && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("w4_done_latency", 32'(cnt), 32'd8);
      tick();
      chk("w4_idle_after", {31'd0, busy2}, 0);
    end

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
